// File: rtl/bcd_conv_scheduler_pkg.sv
// Shared definitions for the BCD converter scheduler: FSM states, default widths
// and the result code returned when the converter times out (BCD_SCHED_TIMEOUT_EN).
package bcd_conv_scheduler_pkg;

  localparam int BIN_W_DEF = 12;
  localparam int BCD_W_DEF = 16;

  localparam logic [15:0] BCD_ERR = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_START,
    ST_WAIT,
    ST_DELIVER
  } state_e;

endpackage

// File: rtl/bcd_conv_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr_i,
// wrapping from NREQ-1 back to 0.
module bcd_rr_arbiter
  import bcd_conv_scheduler_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             valid_o
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = PTR_W'((32'(ptr_i) + 32'(off)) % 32'(NREQ));
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Shares one sequential binary-to-BCD converter between NREQ requesters.
// Optional converter watchdog enabled by defining BCD_SCHED_TIMEOUT_EN.
module bcd_conv_scheduler
  import bcd_conv_scheduler_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int BIN_W   = BIN_W_DEF,
  parameter int BCD_W   = BCD_W_DEF,
  parameter int TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*BIN_W-1:0] req_bin,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [BCD_W-1:0]      rsp_bcd,
  output logic                  rsp_err,
  output logic                  conv_start,
  output logic [BIN_W-1:0]      conv_bin,
  input  logic                  conv_done,
  input  logic [BCD_W-1:0]      conv_bcd,
  output logic                  busy
);

  localparam int PTR_W = $clog2(NREQ);

  state_e            state_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_d;
  logic [PTR_W-1:0]  owner_q;
  logic [NREQ-1:0]   grant_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic              conv_start_q;
  logic [BIN_W-1:0]  conv_bin_q;
  logic [BCD_W-1:0]  rsp_bcd_q;

  logic [NREQ-1:0]   arb_gnt;
  logic [PTR_W-1:0]  arb_idx;
  logic              arb_valid;

  bcd_rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign ptr_d = (arb_idx == PTR_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;

`ifdef BCD_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_q;
  logic             rsp_err_q;
`endif

  // The arbitration decision is registered on the IDLE->GRANT edge so grant is a clean pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      grant_q      <= '0;
      rsp_valid_q  <= '0;
      conv_start_q <= 1'b0;
      conv_bin_q   <= '0;
      rsp_bcd_q    <= '0;
`ifdef BCD_SCHED_TIMEOUT_EN
      wait_cnt_q   <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      grant_q      <= '0;
      rsp_valid_q  <= '0;
      conv_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_q    <= arb_gnt;
            owner_q    <= arb_idx;
            conv_bin_q <= req_bin[arb_idx*BIN_W +: BIN_W];
            ptr_q      <= ptr_d;
            state_q    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          conv_start_q <= 1'b1;
          state_q      <= ST_START;
        end
        ST_START: begin
`ifdef BCD_SCHED_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (conv_done) begin
            rsp_bcd_q   <= conv_bcd;
            rsp_valid_q <= NREQ'(1) << owner_q;
`ifdef BCD_SCHED_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state_q     <= ST_DELIVER;
          end
`ifdef BCD_SCHED_TIMEOUT_EN
          else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            rsp_bcd_q   <= BCD_W'(BCD_ERR);
            rsp_valid_q <= NREQ'(1) << owner_q;
            rsp_err_q   <= 1'b1;
            state_q     <= ST_DELIVER;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        ST_DELIVER: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant      = grant_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_bcd    = rsp_bcd_q;
  assign conv_start = conv_start_q;
  assign conv_bin   = conv_bin_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef BCD_SCHED_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Scoreboard bench for bcd_conv_scheduler with a behavioural converter model.
// Timeout section follows BCD_SCHED_TIMEOUT_EN.
module tb_bcd_conv_scheduler;

  localparam int NREQ  = 3;
  localparam int BIN_W = 12;
  localparam int BCD_W = 16;

  logic                  clk = 1'b0;
  logic                  n_rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*BIN_W-1:0] req_bin;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       rsp_valid;
  logic [BCD_W-1:0]      rsp_bcd;
  logic                  rsp_err;
  logic                  conv_start;
  logic [BIN_W-1:0]      conv_bin;
  logic                  conv_done;
  logic [BCD_W-1:0]      conv_bcd;
  logic                  busy;

  typedef struct {
    int          idx;
    logic [15:0] bcd;
    logic        err;
  } rsp_t;

  rsp_t expRsp[$];
  int   expGrant[$];

  int testsRun    = 0;
  int testsFailed = 0;

  bit silent     = 1'b0;
  int injectCnt  = 0;
  int injectSeen = 0;
  int pokeCnt    = 0;
  int pokeSeen   = 0;

  bcd_conv_scheduler #(
    .NREQ    (NREQ),
    .BIN_W   (BIN_W),
    .BCD_W   (BCD_W),
    .TIMEOUT (32)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .req        (req),
    .req_bin    (req_bin),
    .grant      (grant),
    .rsp_valid  (rsp_valid),
    .rsp_bcd    (rsp_bcd),
    .rsp_err    (rsp_err),
    .conv_start (conv_start),
    .conv_bin   (conv_bin),
    .conv_done  (conv_done),
    .conv_bcd   (conv_bcd),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bin2bcd(input logic [11:0] b);
    int v;
    v = int'(b);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Converter model: answers 13 cycles after conv_start unless silenced.
  initial begin : converter
    logic [11:0] opnd;
    conv_done = 1'b0;
    conv_bcd  = '0;
    forever begin
      @(negedge clk);
      conv_done = 1'b0;
      if (pokeCnt != pokeSeen) begin
        pokeSeen  = pokeCnt;
        conv_done = 1'b1;
        conv_bcd  = 16'hDEAD;
      end else if (conv_start === 1'b1 && !silent) begin
        opnd = conv_bin;
        if (injectCnt != injectSeen) begin
          injectSeen = injectCnt;
          conv_done  = 1'b1;
          conv_bcd   = 16'hDEAD;
        end
        repeat (13) begin
          @(negedge clk);
          conv_done = 1'b0;
        end
        conv_done = 1'b1;
        conv_bcd  = bin2bcd(opnd);
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT shows a grant or a response.
  always @(negedge clk) begin : monitor
    rsp_t e;
    int   w;
    if (n_rst === 1'b1) begin
      if (grant != '0) begin
        if (expGrant.size() == 0) checkOutput("unexpected_grant", 32'(grant), 32'd0);
        else begin
          w = expGrant.pop_front();
          checkOutput("grant", 32'(grant), 32'd1 << w);
        end
      end
      if (rsp_valid != '0) begin
        if (expRsp.size() == 0) checkOutput("unexpected_rsp", 32'(rsp_valid), 32'd0);
        else begin
          e = expRsp.pop_front();
          checkOutput("rsp_valid", 32'(rsp_valid), 32'd1 << e.idx);
          checkOutput("rsp_bcd", 32'(rsp_bcd), 32'(e.bcd));
          checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic pushRsp(input int idx, input logic [15:0] bcd, input logic err);
    rsp_t e;
    e.idx = idx;
    e.bcd = bcd;
    e.err = err;
    expRsp.push_back(e);
  endtask

  task automatic applyStimulus(input logic [2:0] mask, input logic [11:0] v0, input logic [11:0] v1,
                               input logic [11:0] v2);
    req_bin = {v2, v1, v0};
    req     = mask;
    for (int c = 0; c < 300 && req != '0; c++) begin
      @(negedge clk);
      #1;
      req = req & ~grant;
    end
    if (req != '0) checkOutput("req_served_timeout", 32'(req), 32'd0);
    req = '0;
  endtask

  task automatic waitDrain(input string tag);
    for (int c = 0; c < 300; c++) begin
      if (expRsp.size() == 0 && expGrant.size() == 0 && !busy) break;
      @(negedge clk);
      #1;
    end
    checkOutput({tag, "_rsp_drained"}, 32'(expRsp.size()), 32'd0);
    checkOutput({tag, "_busy_drained"}, 32'(busy), 32'd0);
  endtask

  task automatic waitStart(input string tag);
    int c;
    for (c = 0; c < 50; c++) begin
      @(negedge clk);
      #1;
      req = req & ~grant;
      if (conv_start) break;
    end
    if (c == 50) checkOutput({tag, "_start_timeout"}, 32'(conv_start), 32'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_grant"}, 32'(grant), 32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_conv_start"}, 32'(conv_start), 32'd0);
    checkOutput({tag, "_conv_bin"}, 32'(conv_bin), 32'd0);
    checkOutput({tag, "_rsp_bcd"}, 32'(rsp_bcd), 32'd0);
    checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int c;
    n_rst   = 1'b0;
    req     = '0;
    req_bin = '0;
    repeat (2) @(negedge clk);
    #1;
    checkResetState("reset");
    n_rst = 1'b1;
    @(negedge clk);
    #1;

    // Contention from ptr=0: served 0,1,2.
    expGrant.push_back(0); expGrant.push_back(1); expGrant.push_back(2);
    pushRsp(0, 16'h0005, 1'b0);
    pushRsp(1, 16'h0999, 1'b0);
    pushRsp(2, 16'h4095, 1'b0);
    applyStimulus(3'b111, 12'd5, 12'd999, 12'd4095);
    waitDrain("contention");

    // Single request with explicit latency checks; leaves ptr=1.
    expGrant.push_back(0);
    pushRsp(0, 16'h1234, 1'b0);
    req_bin = {12'd0, 12'd0, 12'd1234};
    req     = 3'b001;
    @(negedge clk);
    #1;
    checkOutput("single_grant_latency", 32'(grant), 32'd1);
    req = '0;
    @(negedge clk);
    #1;
    checkOutput("single_start_latency", 32'(conv_start), 32'd1);
    for (c = 1; c <= 40; c++) begin
      @(negedge clk);
      #1;
      if (conv_done) break;
    end
    checkOutput("single_done_cycles", 32'(c), 32'd13);
    @(negedge clk);
    #1;
    checkOutput("single_rsp_latency", 32'(rsp_valid), 32'd1);
    waitDrain("single");

    // ptr=1 with req=011: requester 1 before 0; leaves ptr=1.
    expGrant.push_back(1); expGrant.push_back(0);
    pushRsp(1, 16'h0300, 1'b0);
    pushRsp(0, 16'h0077, 1'b0);
    applyStimulus(3'b011, 12'd77, 12'd300, 12'd0);
    waitDrain("ptr1");

    // Zero operand on requester 1; leaves ptr=2.
    expGrant.push_back(1);
    pushRsp(1, 16'h0000, 1'b0);
    applyStimulus(3'b010, 12'd0, 12'd0, 12'd0);
    waitDrain("zero");

    // Wrap: ptr=2 with req=011 -> requester 0 first.
    expGrant.push_back(0); expGrant.push_back(1);
    pushRsp(0, 16'h4095, 1'b0);
    pushRsp(1, 16'h0042, 1'b0);
    applyStimulus(3'b011, 12'd4095, 12'd42, 12'd0);
    waitDrain("wrap");

    // Spurious conv_done during START must not be taken as the result.
    injectCnt++;
    expGrant.push_back(2);
    pushRsp(2, 16'h0007, 1'b0);
    applyStimulus(3'b100, 12'd0, 12'd0, 12'd7);
    waitDrain("start_done");

    // Reset mid-WAIT, then the stale conv_done lands in IDLE.
    expGrant.push_back(0);
    req_bin = {12'd0, 12'd0, 12'd321};
    req     = 3'b001;
    waitStart("rst_wait");
    req = '0;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("busy_in_wait", 32'(busy), 32'd1);
    n_rst = 1'b0;
    #1;
    checkResetState("mid_wait_reset");
    repeat (2) @(negedge clk);
    #1;
    n_rst = 1'b1;
    repeat (15) @(negedge clk);
    pokeCnt++;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("stale_done_busy", 32'(busy), 32'd0);
    checkOutput("stale_done_bcd", 32'(rsp_bcd), 32'd0);

    // Pointer restarted at 0 by reset: req=011 -> 0 then 1.
    expGrant.push_back(0); expGrant.push_back(1);
    pushRsp(0, 16'h0808, 1'b0);
    pushRsp(1, 16'h0016, 1'b0);
    applyStimulus(3'b011, 12'd808, 12'd16, 12'd0);
    waitDrain("post_reset");

    // Converter never answers.
    silent = 1'b1;
    expGrant.push_back(1);
`ifdef BCD_SCHED_TIMEOUT_EN
    pushRsp(1, 16'hFFFF, 1'b1);
`endif
    req_bin = {12'd0, 12'd55, 12'd0};
    req     = 3'b010;
    waitStart("silent");
    req = '0;
`ifdef BCD_SCHED_TIMEOUT_EN
    for (c = 1; c <= 60; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid != '0) break;
    end
    checkOutput("timeout_latency", 32'(c), 32'd33);
    silent = 1'b0;
    waitDrain("timeout");
    expGrant.push_back(0);
    pushRsp(0, 16'h0009, 1'b0);
    applyStimulus(3'b001, 12'd9, 12'd0, 12'd0);
    waitDrain("after_timeout");
`else
    repeat (100) @(negedge clk);
    #1;
    checkOutput("hang_busy", 32'(busy), 32'd1);
    checkOutput("hang_rsp_err", 32'(rsp_err), 32'd0);
    n_rst = 1'b0;
    #1;
    checkResetState("hang_reset");
    silent = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_rst = 1'b1;
    @(negedge clk);
    #1;
`endif

    checkOutput("final_grant_queue", 32'(expGrant.size()), 32'd0);
    checkOutput("final_rsp_queue", 32'(expRsp.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
